// File: rtl/vga_cfg_pkg.sv
// Purpose: shared types and constants for the VGA configuration controller.
// Holds opcode defaults, the controller state enum, status-byte bit indices
// and the character-memory address type.
package vga_cfg_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned CFG_W   = 32;
   localparam int unsigned STAGE_W = 24;
   localparam int unsigned ADDR_W  = 5;

   localparam logic [BYTE_W-1:0] OP_CFG_DEF  = 8'h01;
   localparam logic [BYTE_W-1:0] OP_CHAR_DEF = 8'h02;
   localparam logic [BYTE_W-1:0] OP_STAT_DEF = 8'h03;

   // Status byte layout: {cfg_pending, char_wait, err_sticky, 5'b0}
   localparam int unsigned STAT_PEND_BIT = 7;
   localparam int unsigned STAT_WAIT_BIT = 6;
   localparam int unsigned STAT_ERR_BIT  = 5;

   typedef logic [ADDR_W-1:0] char_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CFG       = 3'd1,
      ST_CHAR_ADDR = 3'd2,
      ST_CHAR_DATA = 3'd3,
      ST_CHAR_WAIT = 3'd4,
      ST_DRAIN     = 3'd5
   } state_t;

endpackage

// File: rtl/cfg_shadow.sv
// Purpose: configuration staging/shadow registers with frame-synchronous commit.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_shift           - shift i_byte into the 24-bit staging register
//   i_load            - 4th byte: copy {staging, i_byte} into shadow, set pending
//   i_clear           - discard staging contents (aborted transaction)
//   i_byte            - received byte
//   i_frame_start     - start-of-vertical-blanking pulse
//   o_cfg_out         - committed configuration word
//   o_cfg_update      - one-cycle pulse when o_cfg_out is loaded
//   o_pending         - shadow holds an uncommitted configuration
module cfg_shadow
   import vga_cfg_pkg::*;
#(
   parameter logic [CFG_W-1:0] CFG_RESET = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_shift,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_frame_start,
   output logic [CFG_W-1:0]  o_cfg_out,
   output logic              o_cfg_update,
   output logic              o_pending
);

   logic [STAGE_W-1:0] r_staging;
   logic [CFG_W-1:0]   r_shadow;
   logic [CFG_W-1:0]   r_cfg_out;
   logic               r_cfg_update;
   logic               r_pending;
   logic               w_commit;

   // Commit only what was pending before this edge; a load on the same edge
   // as frame_start waits for the next frame.
   assign w_commit = i_frame_start & r_pending;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_staging    <= '0;
         r_shadow     <= CFG_RESET;
         r_cfg_out    <= CFG_RESET;
         r_cfg_update <= 1'b0;
         r_pending    <= 1'b0;
      end else begin
         r_cfg_update <= 1'b0;

         if (i_clear) begin
            r_staging <= '0;
         end else if (i_shift) begin
            r_staging <= {r_staging[STAGE_W-BYTE_W-1:0], i_byte};
         end

         if (i_load) begin
            r_shadow <= {r_staging, i_byte};
         end

         if (w_commit) begin
            r_cfg_out    <= r_shadow;
            r_cfg_update <= 1'b1;
         end

         // A fresh load keeps pending set even if an older value commits now
         if (i_load) begin
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign o_cfg_out    = r_cfg_out;
   assign o_cfg_update = r_cfg_update;
   assign o_pending    = r_pending;

endmodule

// File: rtl/vga_cfg_ctrl.sv
// Purpose: SPI byte-protocol controller for VGA configuration and character memory.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rx_valid      - strobe, rx_data holds a received SPI byte
//   rx_data       - received byte
//   ss            - SPI slave select, active-low
//   frame_start   - start-of-vertical-blanking pulse
//   active        - high during visible pixels
//   cfg_out       - committed configuration word
//   cfg_update    - pulse when cfg_out is loaded
//   mem_we        - character-memory write strobe
//   mem_addr      - character-memory address {y[2:0], x[1:0]}
//   mem_data      - character-memory write bit
//   tx_data       - status byte for the SPI peripheral
//   tx_load       - pulse, tx_data valid
//   err           - protocol-error pulse
module vga_cfg_ctrl
   import vga_cfg_pkg::*;
#(
   parameter logic [CFG_W-1:0]  CFG_RESET = 32'h0000_0000,
   parameter logic [BYTE_W-1:0] OP_CFG    = OP_CFG_DEF,
   parameter logic [BYTE_W-1:0] OP_CHAR   = OP_CHAR_DEF,
   parameter logic [BYTE_W-1:0] OP_STAT   = OP_STAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              ss,
   input  logic              frame_start,
   input  logic              active,
   output logic [CFG_W-1:0]  cfg_out,
   output logic              cfg_update,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_data,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_load,
   output logic              err
);

   state_t            r_state;
   logic [1:0]        r_cnt;
   char_addr_t        r_mem_addr;
   logic              r_mem_data;
   logic              r_mem_we;
   logic [BYTE_W-1:0] r_tx_data;
   logic              r_tx_load;
   logic              r_err;
   logic              r_err_sticky;

   state_t            w_state_nxt;
   logic [1:0]        w_cnt_nxt;
   char_addr_t        w_addr_nxt;
   logic              w_data_nxt;
   logic              w_mem_we_nxt;
   logic              w_err_nxt;
   logic              w_stat_load;
   logic              w_cfg_shift;
   logic              w_cfg_load;
   logic              w_cfg_clear;
   logic              w_rx;
   logic              w_pending;
   logic [BYTE_W-1:0] w_status;

   // Configuration staging, shadow and frame-synchronous commit
   cfg_shadow #(
      .CFG_RESET (CFG_RESET)
   ) u_cfg_shadow (
      .clk           (clk),
      .rst           (rst),
      .i_shift       (w_cfg_shift),
      .i_load        (w_cfg_load),
      .i_clear       (w_cfg_clear),
      .i_byte        (rx_data),
      .i_frame_start (frame_start),
      .o_cfg_out     (cfg_out),
      .o_cfg_update  (cfg_update),
      .o_pending     (w_pending)
   );

   // Bytes only count while the slave is selected
   assign w_rx = rx_valid & ~ss;

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_addr_nxt   = r_mem_addr;
      w_data_nxt   = r_mem_data;
      w_mem_we_nxt = 1'b0;
      w_err_nxt    = 1'b0;
      w_stat_load  = 1'b0;
      w_cfg_shift  = 1'b0;
      w_cfg_load   = 1'b0;
      w_cfg_clear  = 1'b0;

      w_status                = '0;
      w_status[STAT_PEND_BIT] = w_pending;
      w_status[STAT_WAIT_BIT] = (r_state == ST_CHAR_WAIT);
      w_status[STAT_ERR_BIT]  = r_err_sticky;

      // Deselect aborts everything except a write already waiting for blanking
      if (ss && (r_state != ST_CHAR_WAIT)) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = 2'd0;
         w_cfg_clear = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rx) begin
                  if (rx_data == OP_CFG) begin
                     w_state_nxt = ST_CFG;
                     w_cnt_nxt   = 2'd0;
                  end else if (rx_data == OP_CHAR) begin
                     w_state_nxt = ST_CHAR_ADDR;
                  end else if (rx_data == OP_STAT) begin
                     w_stat_load = 1'b1;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = ST_DRAIN;
                  end
               end
            end
            ST_CFG: begin
               if (w_rx) begin
                  if (r_cnt == 2'd3) begin
                     w_cfg_load  = 1'b1;
                     w_cnt_nxt   = 2'd0;
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_cfg_shift = 1'b1;
                     w_cnt_nxt   = 2'(r_cnt + 2'd1);
                  end
               end
            end
            ST_CHAR_ADDR: begin
               if (w_rx) begin
                  w_addr_nxt  = char_addr_t'(rx_data[ADDR_W-1:0]);
                  w_state_nxt = ST_CHAR_DATA;
               end
            end
            ST_CHAR_DATA: begin
               if (w_rx) begin
                  w_data_nxt = rx_data[0];
                  if (!active) begin
                     w_mem_we_nxt = 1'b1;
                     w_state_nxt  = ST_IDLE;
                  end else begin
                     w_state_nxt  = ST_CHAR_WAIT;
                  end
               end
            end
            ST_CHAR_WAIT: begin
               // Any byte here is dropped and flagged
               if (w_rx) begin
                  w_err_nxt = 1'b1;
               end
               if (!active) begin
                  w_mem_we_nxt = 1'b1;
                  w_state_nxt  = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               w_state_nxt = ST_DRAIN;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 2'd0;
         r_mem_addr   <= '0;
         r_mem_data   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_tx_data    <= '0;
         r_tx_load    <= 1'b0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_mem_addr <= w_addr_nxt;
         r_mem_data <= w_data_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_tx_load  <= w_stat_load;
         r_err      <= w_err_nxt;
         if (w_stat_load) begin
            r_tx_data <= w_status;
         end
         // A new error wins over the clear-on-read
         if (w_err_nxt) begin
            r_err_sticky <= 1'b1;
         end else if (w_stat_load) begin
            r_err_sticky <= 1'b0;
         end
      end
   end

   assign mem_we   = r_mem_we;
   assign mem_addr = r_mem_addr;
   assign mem_data = r_mem_data;
   assign tx_data  = r_tx_data;
   assign tx_load  = r_tx_load;
   assign err      = r_err;

endmodule

// File: tb/tb_vga_cfg_ctrl.sv
// Purpose: directed scoreboard bench for vga_cfg_ctrl. Stimulus pushes the
// expected pulse (value and cycle) per output kind; a negedge monitor pops and
// compares whenever cfg_update, mem_we, tx_load or err is seen.
module tb_vga_cfg_ctrl;

   localparam logic [31:0] RST_CFG = 32'hC0FF_EE00;
   localparam int K_NONE = 0;
   localparam int K_CFG  = 1;
   localparam int K_MEM  = 2;
   localparam int K_TX   = 3;
   localparam int K_ERR  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        ss = 1'b1;
   logic        frame_start = 1'b0;
   logic        active = 1'b0;
   logic [31:0] cfg_out;
   logic        cfg_update;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic        mem_data;
   logic [7:0]  tx_data;
   logic        tx_load;
   logic        err;

   typedef struct packed {
      logic [31:0] val;
      logic [31:0] cyc;
   } exp_t;

   exp_t        q_cfg[$];
   exp_t        q_mem[$];
   exp_t        q_tx[$];
   exp_t        q_err[$];
   exp_t        m_e;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] cyc = 32'd0;

   vga_cfg_ctrl #(
      .CFG_RESET (RST_CFG)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .ss          (ss),
      .frame_start (frame_start),
      .active      (active),
      .cfg_out     (cfg_out),
      .cfg_update  (cfg_update),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response to something driven now is registered on the next edge
   task automatic expect_evt(input int kind, input logic [31:0] val);
      exp_t e;
      e.val = val;
      e.cyc = cyc + 32'd1;
      case (kind)
         K_CFG:   q_cfg.push_back(e);
         K_MEM:   q_mem.push_back(e);
         K_TX:    q_tx.push_back(e);
         K_ERR:   q_err.push_back(e);
         default: ;
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b, input int kind, input logic [31:0] val,
                            input logic fs);
      @(negedge clk);
      rx_valid    = 1'b1;
      rx_data     = b;
      frame_start = fs;
      expect_evt(kind, val);
      @(negedge clk);
      rx_valid    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic frame(input int kind, input logic [31:0] val);
      @(negedge clk);
      frame_start = 1'b1;
      expect_evt(kind, val);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      check("reset cfg_out", cfg_out, RST_CFG);
      check("reset pulses", {28'd0, cfg_update, mem_we, tx_load, err}, 32'd0);
      check("reset tx_data", {24'd0, tx_data}, 32'd0);
      check("reset mem_addr/data", {26'd0, mem_addr, mem_data}, 32'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (cfg_update) begin
         if (q_cfg.size() == 0) check("cfg_update unexpected", {31'd0, cfg_update}, 32'd0);
         else begin
            m_e = q_cfg.pop_front();
            check("cfg_out value", cfg_out, m_e.val);
            check("cfg_update cycle", cyc, m_e.cyc);
         end
      end
      if (mem_we) begin
         if (q_mem.size() == 0) check("mem_we unexpected", {31'd0, mem_we}, 32'd0);
         else begin
            m_e = q_mem.pop_front();
            check("mem addr/data", {26'd0, mem_addr, mem_data}, m_e.val);
            check("mem_we cycle", cyc, m_e.cyc);
         end
      end
      if (tx_load) begin
         if (q_tx.size() == 0) check("tx_load unexpected", {31'd0, tx_load}, 32'd0);
         else begin
            m_e = q_tx.pop_front();
            check("tx_data", {24'd0, tx_data}, m_e.val);
            check("tx_load cycle", cyc, m_e.cyc);
         end
      end
      if (err) begin
         if (q_err.size() == 0) check("err unexpected", {31'd0, err}, 32'd0);
         else begin
            m_e = q_err.pop_front();
            check("err cycle", cyc, m_e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      idle(3);
      check_reset_outputs();
      rst = 1'b0;
      ss  = 1'b0;

      // CFG commit on frame_start
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      send_byte(8'hDE, K_NONE, 32'h0, 1'b0);
      send_byte(8'hAD, K_NONE, 32'h0, 1'b0);
      send_byte(8'hBE, K_NONE, 32'h0, 1'b0);
      send_byte(8'hEF, K_NONE, 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("cfg_out before frame", cfg_out, RST_CFG);
      end
      frame(K_CFG, 32'hDEAD_BEEF);
      idle(2);
      check("cfg_out after frame", cfg_out, 32'hDEAD_BEEF);

      // 4th byte coincident with frame_start: commit waits a frame
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      send_byte(8'h11, K_NONE, 32'h0, 1'b0);
      send_byte(8'h22, K_NONE, 32'h0, 1'b0);
      send_byte(8'h33, K_NONE, 32'h0, 1'b0);
      send_byte(8'h44, K_NONE, 32'h0, 1'b1);
      idle(3);
      check("cfg_out after coincident frame", cfg_out, 32'hDEAD_BEEF);
      frame(K_CFG, 32'h1122_3344);
      idle(2);

      // Blanked character write
      active = 1'b0;
      send_byte(8'h02, K_NONE, 32'h0, 1'b0);
      send_byte(8'h13, K_NONE, 32'h0, 1'b0);
      send_byte(8'h01, K_MEM, 32'h27, 1'b0);
      idle(3);

      // Active character write: waits for blanking, extra byte flagged
      active = 1'b1;
      send_byte(8'h02, K_NONE, 32'h0, 1'b0);
      send_byte(8'h13, K_NONE, 32'h0, 1'b0);
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      idle(5);
      send_byte(8'h55, K_ERR, 32'h0, 1'b0);
      idle(12);
      @(negedge clk);
      active = 1'b0;
      expect_evt(K_MEM, 32'h27);
      idle(2);
      send_byte(8'h03, K_TX, 32'h20, 1'b0);
      idle(1);
      send_byte(8'h03, K_TX, 32'h00, 1'b0);
      idle(2);

      // Partial CFG aborted by ss: shadow untouched, back in IDLE
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      send_byte(8'h11, K_NONE, 32'h0, 1'b0);
      send_byte(8'h22, K_NONE, 32'h0, 1'b0);
      ss = 1'b1;
      idle(2);
      ss = 1'b0;
      frame(K_NONE, 32'h0);
      idle(2);
      check("cfg_out after abort", cfg_out, 32'h1122_3344);
      send_byte(8'h03, K_TX, 32'h00, 1'b0);

      // Bad opcode: err, then drain until ss
      send_byte(8'h7F, K_ERR, 32'h0, 1'b0);
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      send_byte(8'h03, K_NONE, 32'h0, 1'b0);
      send_byte(8'h02, K_NONE, 32'h0, 1'b0);
      ss = 1'b1;
      idle(2);
      ss = 1'b0;
      send_byte(8'h03, K_TX, 32'h20, 1'b0);

      // Reset with a pending CFG and a write waiting in CHAR_WAIT
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      send_byte(8'h12, K_NONE, 32'h0, 1'b0);
      send_byte(8'h34, K_NONE, 32'h0, 1'b0);
      send_byte(8'h56, K_NONE, 32'h0, 1'b0);
      send_byte(8'h78, K_NONE, 32'h0, 1'b0);
      active = 1'b1;
      send_byte(8'h02, K_NONE, 32'h0, 1'b0);
      send_byte(8'h05, K_NONE, 32'h0, 1'b0);
      send_byte(8'h01, K_NONE, 32'h0, 1'b0);
      idle(2);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      check_reset_outputs();
      rst    = 1'b0;
      active = 1'b0;
      idle(3);
      frame(K_NONE, 32'h0);
      idle(4);
      check("cfg_out after mid-op reset", cfg_out, RST_CFG);
      send_byte(8'h03, K_TX, 32'h00, 1'b0);
      idle(3);

      check("leftover cfg events", 32'(q_cfg.size()), 32'd0);
      check("leftover mem events", 32'(q_mem.size()), 32'd0);
      check("leftover tx events", 32'(q_tx.size()), 32'd0);
      check("leftover err events", 32'(q_err.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
